// File: rtl/palette_fader.sv
// palette_fader: writable RGB palette selected by SW, driving a registered
// output colour that either tracks the selected entry or fades linearly to it.
//
// state | meaning
// IDLE  | colour equals target, or direct mode is selected
// FADE  | colour stepping toward target once per prescaled tick
module palette_fader #(
    parameter int IDX_W    = 4,
    parameter int CH_W     = 8,
    parameter int STEP     = 1,
    parameter int STEP_DIV = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IDX_W-1:0]    SW,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                fade_en,
    output logic [3*CH_W-1:0]   color,
    output logic                busy
);

    localparam int N  = 1 << IDX_W;
    localparam int CW = 3 * CH_W;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(STEP_DIV - 1);
    localparam logic [CH_W-1:0] STEP_C  = CH_W'(STEP);
    localparam logic [CH_W:0]   STEP_X  = (CH_W + 1)'(STEP);

    typedef enum logic {IDLE, FADE} state_t;

    state_t           state;
    logic [PW-1:0]    prescaler;
    logic [CW-1:0]    target_r;
    logic [CW-1:0]    pal [N];
    logic             tick;
    logic [CW-1:0]    fade_next;

    // An 8-bit table value mapped onto CH_W bits, MSB-aligned, repeating the
    // source bits when the channel is wider than 8.
    function automatic logic [CH_W-1:0] chan8(input logic [7:0] v);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < CH_W; i++) begin
            r[CH_W-1-i] = v[7-(i%8)];
        end
        return r;
    endfunction

    // Standard colour set, counted down from the top entry.
    function automatic logic [CW-1:0] default_entry(input int idx);
        logic [23:0] rgb;
        rgb = 24'h000000;
        case (N - 1 - idx)
            0: rgb = 24'hFFFFFF;
            1: rgb = 24'hFF0000;
            2: rgb = 24'h00FF00;
            3: rgb = 24'h0000FF;
            4: rgb = 24'hFFFF00;
            5: rgb = 24'hFF00FF;
            6: rgb = 24'h00FFFF;
            7: rgb = 24'hCEF60A;
            8: rgb = 24'h555555;
            9: rgb = 24'hAAAAAA;
            default: rgb = 24'h000000;
        endcase
        return {chan8(rgb[23:16]), chan8(rgb[15:8]), chan8(rgb[7:0])};
    endfunction

    // One channel moves STEP toward its target, landing exactly when close.
    function automatic logic [CH_W-1:0] step_chan(input logic [CH_W-1:0] c,
                                                  input logic [CH_W-1:0] t);
        logic [CH_W:0] d;
        logic [CH_W-1:0] r;
        if (t >= c) begin
            d = {1'b0, t} - {1'b0, c};
            r = (d <= STEP_X) ? t : c + STEP_C;
        end else begin
            d = {1'b0, c} - {1'b0, t};
            r = (d <= STEP_X) ? t : c - STEP_C;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] step_color(input logic [CW-1:0] c,
                                                 input logic [CW-1:0] t);
        logic [CW-1:0] r;
        r = c;
        for (int ch = 0; ch < 3; ch++) begin
            r[ch*CH_W +: CH_W] = step_chan(c[ch*CH_W +: CH_W], t[ch*CH_W +: CH_W]);
        end
        return r;
    endfunction

    // Palette storage, reloaded with the standard set on reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                pal[i] <= default_entry(i);
            end
        end else if (wr_en) begin
            pal[wr_idx] <= wr_data;
        end
    end

    // Selected entry, with a same-cycle write to that entry taking precedence.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            target_r <= '0;
        end else begin
            target_r <= (wr_en && (wr_idx == SW)) ? wr_data : pal[SW];
        end
    end

    // Candidate colour for this cycle while fading.
    always_comb begin
        tick      = (prescaler == PS_LAST);
        fade_next = tick ? step_color(color, target_r) : color;
    end

    // Mode/fade sequencer; busy and colour are registered here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            prescaler <= '0;
            color     <= '0;
            busy      <= 1'b0;
        end else if (!fade_en) begin
            state <= IDLE;
            color <= target_r;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (color != target_r) begin
                        state     <= FADE;
                        prescaler <= '0;
                        busy      <= 1'b1;
                    end
                end
                FADE: begin
                    prescaler <= tick ? '0 : prescaler + PW'(1);
                    color     <= fade_next;
                    // Completion is judged on the colour being written now.
                    if (fade_next == target_r) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_fader.sv
module tb_palette_fader;

    logic        CLK;
    logic        RST;
    logic [3:0]  SW;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [23:0] wr_data;
    logic        fade_en;
    logic [23:0] color_a, color_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    // dut_a: default parameters; dut_b: coarse step, one tick per cycle
    palette_fader dut_a (
        .CLK(CLK), .RST(RST), .SW(SW), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .fade_en(fade_en), .color(color_a), .busy(busy_a)
    );

    palette_fader #(.STEP(16), .STEP_DIV(1)) dut_b (
        .CLK(CLK), .RST(RST), .SW(SW), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .fade_en(fade_en), .color(color_b), .busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int defs [10] = '{32'hFFFFFF, 32'hFF0000, 32'h00FF00, 32'h0000FF, 32'hFFFF00,
                      32'hFF00FF, 32'h00FFFF, 32'hCEF60A, 32'h555555, 32'hAAAAAA};
    int stp [2] = '{1, 16};
    int dv  [2] = '{4, 1};
    int mpal [2][16];
    int mcol [2];
    int mtgt [2];
    int mbusy[2];
    int mcnt [2];

    function automatic int fade_step(input int c, input int t, input int st);
        int r;
        r = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int cc, tt, d;
            cc = (c >> (8*ch)) & 255;
            tt = (t >> (8*ch)) & 255;
            d  = tt - cc;
            if (d <= st && d >= -st) cc = tt;
            else if (d > 0) cc = cc + st;
            else cc = cc - st;
            r = r | (cc << (8*ch));
        end
        return r;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int m = 0; m < 2; m++) begin
                mcol[m] = 0; mtgt[m] = 0; mbusy[m] = 0; mcnt[m] = 0;
                for (int i = 0; i < 16; i++) mpal[m][i] = (i >= 6) ? defs[15-i] : 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int ntgt;
                ntgt = (wr_en && wr_idx == SW) ? int'(wr_data) : mpal[m][SW];
                if (wr_en) mpal[m][wr_idx] = int'(wr_data);
                if (!fade_en) begin
                    mcol[m] = mtgt[m];
                    mbusy[m] = 0;
                end else if (mbusy[m] == 0) begin
                    if (mcol[m] != mtgt[m]) begin
                        mbusy[m] = 1;
                        mcnt[m] = 0;
                    end
                end else begin
                    mcnt[m]++;
                    if (mcnt[m] % dv[m] == 0) mcol[m] = fade_step(mcol[m], mtgt[m], stp[m]);
                    if (mcol[m] == mtgt[m]) mbusy[m] = 0;
                end
                mtgt[m] = ntgt;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        chk("model_color_a", {8'h0, color_a}, mcol[0]);
        chk("model_busy_a", {31'h0, busy_a}, mbusy[0]);
        chk("model_color_b", {8'h0, color_b}, mcol[1]);
        chk("model_busy_b", {31'h0, busy_b}, mbusy[1]);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic [23:0] exp_sw [16] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000,
                                 24'h000000, 24'h000000, 24'hAAAAAA, 24'h555555,
                                 24'hCEF60A, 24'h00FFFF, 24'hFF00FF, 24'hFFFF00,
                                 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        RST = 1'b0; SW = 4'd0; wr_en = 1'b0; wr_idx = 4'd0; wr_data = 24'h0; fade_en = 1'b0;
        #3;
        chk("reset_color", {8'h0, color_a}, 32'h0);
        chk("reset_busy", {31'h0, busy_a}, 32'h0);
        edges(3);
        RST = 1'b1;
        edges(1);

        // direct-mode sweep, 2-cycle latency
        for (int s = 0; s < 16; s++) begin
            SW = 4'(s);
            edges(2);
            chk($sformatf("sweep_sw%0d", s), {8'h0, color_a}, {8'h0, exp_sw[s]});
        end

        // write with bypass to the selected entry
        SW = 4'd5;
        edges(2);
        wr_en = 1'b1; wr_idx = 4'd5; wr_data = 24'h123456;
        edges(1);
        wr_en = 1'b0;
        edges(1);
        chk("bypass_write", {8'h0, color_a}, 32'h123456);
        wr_en = 1'b1; wr_idx = 4'd4; wr_data = 24'h654321;
        edges(1);
        wr_en = 1'b0;
        edges(2);
        chk("other_write", {8'h0, color_a}, 32'h123456);

        // coarse step fade on dut_b
        SW = 4'd3; edges(2);
        fade_en = 1'b1; SW = 4'd8;
        edges(2);
        chk("coarse_busy", {31'h0, busy_b}, 32'h1);
        edges(13);
        chk("coarse_13", {8'h0, color_b}, 32'hCED00A);
        edges(3);
        chk("coarse_done", {8'h0, color_b}, 32'hCEF60A);
        chk("coarse_busy_low", {31'h0, busy_b}, 32'h0);

        // full fade 000000 -> FFFFFF on dut_a
        fade_en = 1'b0; SW = 4'd3; edges(2);
        fade_en = 1'b1; SW = 4'd15;
        edges(2);
        chk("fade_busy", {31'h0, busy_a}, 32'h1);
        edges(4);
        chk("fade_first_step", {8'h0, color_a}, 32'h010101);
        n = 4;
        while (busy_a && n < 2000) begin
            edges(1);
            n++;
        end
        chk("fade_cycles", n, 32'd1020);
        chk("fade_final", {8'h0, color_a}, 32'hFFFFFF);

        // retarget mid-fade
        fade_en = 1'b0; SW = 4'd3; edges(2);
        fade_en = 1'b1; SW = 4'd15;
        edges(514);
        chk("mid_808080", {8'h0, color_a}, 32'h808080);
        SW = 4'd3;
        edges(4);
        chk("retarget_step", {8'h0, color_a}, 32'h7F7F7F);
        chk("retarget_busy", {31'h0, busy_a}, 32'h1);

        // drop fade_en mid-fade
        SW = 4'd15;
        edges(10);
        fade_en = 1'b0;
        edges(1);
        chk("drop_color", {8'h0, color_a}, 32'hFFFFFF);
        chk("drop_busy", {31'h0, busy_a}, 32'h0);

        // asynchronous reset mid-fade
        fade_en = 1'b1; SW = 4'd3;
        edges(8);
        chk("pre_reset_busy", {31'h0, busy_a}, 32'h1);
        #2 RST = 1'b0;
        #1;
        chk("async_color", {8'h0, color_a}, 32'h0);
        chk("async_busy", {31'h0, busy_a}, 32'h0);
        edges(2);
        RST = 1'b1; fade_en = 1'b0; SW = 4'd5;
        edges(2);
        chk("pal_reset", {8'h0, color_a}, 32'h0);
        SW = 4'd15;
        edges(2);
        chk("post_reset_sw15", {8'h0, color_a}, 32'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_fader.md
# palette_fader

Parametrised successor to the fixed switch-to-colour lookup. It holds a writable N-entry RGB palette, initialised at reset to the standard colour set, and selects one entry with the switch inputs. The output colour either follows the selected entry directly or fades linearly toward it, one channel step per prescaled tick. It sits between the switch/register interface and the display colour path.

## Interface
- IDX_W, 4: selector/index width; palette depth N = 2^IDX_W; must be >= 4.
- CH_W, 8: bits per colour channel; the colour word is 3*CH_W wide, ordered {R,G,B}.
- STEP, 1: per-tick channel increment; range 1..2^CH_W-1.
- STEP_DIV, 4: clock cycles per fade tick; must be >= 1.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- SW  in  IDX_W  palette index selector.
- wr_en  in  1  palette write strobe.
- wr_idx  in  IDX_W  palette entry to write.
- wr_data  in  3*CH_W  colour to write.
- fade_en  in  1  1 = fade mode, 0 = direct mode.
- color  out  3*CH_W  registered output colour.
- busy  out  1  high while a fade is in progress (FADE state).

## Operation
- Reset (RST=0, asynchronous): color=0, busy=0, target_r=0, prescaler=0, state=IDLE.
- Palette reset contents: with k counted from the top (entry N-1-k):
  - k=0..9: FFFFFF, FF0000, 00FF00, 0000FF, FFFF00, FF00FF, 00FFFF, CEF60A, 555555, AAAAAA.
  - All other entries: 0.
  - For CH_W≠8, each 8-bit channel value is replicated or truncated MSB-aligned.
- Palette write: when wr_en=1, entry wr_idx ← wr_data at the edge.
- Target register, updated every cycle: target_r ← (wr_en && wr_idx==SW) ? wr_data : pal[SW]. Write-bypass applies when the write and the selection hit the same entry.
- Direct mode (fade_en=0): color ← target_r every cycle; state=IDLE; busy=0.
- State machine:
  - IDLE→FADE when fade_en=1 and color≠target_r. The prescaler clears to 0 on entry.
  - In FADE, the prescaler counts 0..STEP_DIV-1 and wraps. A tick occurs on the cycle it equals STEP_DIV-1.
  - On each tick, per channel independently: if |target−color| ≤ STEP, channel ← target; otherwise channel moves by STEP toward target. No overflow or underflow is possible.
  - FADE→IDLE on the edge where color==target_r. This includes the tick that completes the fade; the FADE→IDLE check uses post-update values.
- Target change during FADE: continue from the current color toward the new target; the prescaler is not restarted. If the new target equals the current color, go to IDLE.
- fade_en falls during FADE: next edge color←target_r, state=IDLE, busy=0.
- Reset during FADE: immediate asynchronous return to reset values.

## Timing
- SW change → target_r: 1 cycle. target_r → color in direct mode: 1 cycle. Total SW → color latency is 2 cycles.
- Write to the selected entry → color in direct mode: 2 cycles after the wr_en edge, through the bypass.
- busy rises 1 cycle after target_r differs from color with fade_en=1.
- First fade step occurs STEP_DIV cycles after FADE entry.
- Fade duration in ticks: ceil(max channel |diff| / STEP). In cycles: that value × STEP_DIV.
- busy falls on the same edge that writes the final step.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then direct mode: RST low→high, fade_en=0. Sweep SW 0..15; color equals the default table 2 cycles after each change (SW=15→FFFFFF, SW=8→CEF60A, SW=6→AAAAAA, SW=3→000000).
- Write/bypass: SW=5, wr_en=1, wr_idx=5, wr_data=123456 for one cycle. color=123456 two edges later. Writing idx 4 instead leaves color unchanged.
- Fade: default params, color=000000, fade_en=1, SW=15. busy=1; color steps 010101 every 4 cycles. Reaches FFFFFF after 255 ticks (1020 cycles); busy falls on that edge.
- Coarse step: STEP=16, STEP_DIV=1, 000000→CEF60A. Per channel, R reaches CE and then holds while G continues. Done after 16 ticks (F6/16 rounded up). Final color exactly CEF60A.
- Mid-fade events:
  - Retarget from FFFFFF to 000000 at color 808080: color reverses without restart.
  - Drop fade_en: color snaps to the target next edge, busy=0.
  - Assert RST: color=0 and busy=0 immediately, without a clock edge.
